pe_spad_ctrl: RTL
=================

# pe_spad_ctrl

Controller that sequences one PE scratchpad (single-port, synchronous write, combinational read while write-enable is low) between a fill phase and a reuse read phase. It accepts a job descriptor, streams `len` words from the global-buffer side into the scratchpad, then replays them `reuse+1` times to the MAC datapath through a registered, back-pressurable output. It sits between the PE input FIFO and the MAC and owns the scratchpad's address, write-enable and write-data pins.

## Interface
- `WIDTH`, 8, word width in bits.
- `ADDR`, 6, scratchpad address width in bits.
- `SIZE`, 64, scratchpad depth in words; `SIZE` ≤ 2^`ADDR`.
- `clk` input 1 — the single clock; all state changes on the rising edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `cfg_valid` input 1 — job descriptor valid.
- `cfg_ready` output 1 — high only in IDLE.
- `cfg_len` input ADDR+1 — words per pass; values above `SIZE` are clamped to `SIZE`.
- `cfg_reuse` input 8 — number of extra read passes; total passes = `cfg_reuse`+1.
- `cfg_keep` input 1 — skip FILL and replay the current scratchpad contents.
- `in_valid` input 1, `in_ready` output 1, `in_data` input WIDTH — fill stream.
- `out_valid` output 1, `out_ready` input 1, `out_data` output WIDTH — read stream to the MAC.
- `out_last` output 1 — qualifies the final word of each pass.
- `done` output 1 — one-cycle pulse when the job completes.
- `spad_wen` output 1, `spad_addr` output ADDR, `spad_wrdata` output WIDTH — scratchpad drive pins.
- `spad_rdata` input WIDTH — scratchpad read data.

## Operation
- FSM states: IDLE, FILL, READ, DRAIN.
- IDLE: `cfg_ready`=1. On a `cfg_valid` handshake, latch len (clamped), reuse and keep.
  - len=0: `done` pulses on the next cycle and the FSM stays in IDLE.
  - keep=1: go to READ.
  - Otherwise: go to FILL.
- FILL: `in_ready`=1. Each `in_valid` handshake drives `spad_wen`=1, `spad_addr`=wr_ptr, `spad_wrdata`=`in_data`, then increments wr_ptr. The handshake on word len-1 moves the FSM to READ. `spad_wen` is never high outside a FILL handshake.
- READ: `spad_wen`=0 and `spad_addr`=rd_ptr.
  - A read issues when the output register is empty or is being consumed in the same cycle (`!out_valid || out_ready`). On issue, the register loads `spad_rdata`, `out_last` loads (rd_ptr==len-1), and rd_ptr advances.
  - rd_ptr wraps from len-1 to 0 and increments the pass counter.
  - Issuing the final word of the final pass moves the FSM to DRAIN.
- DRAIN: no issue. The handshake on the final word pulses `done` on the next cycle and returns the FSM to IDLE.
- Arithmetic: wr_ptr and rd_ptr are ADDR bits; the pass counter is 9 bits and compares against reuse (8 bits, zero-extended).
- Invariant: one scratchpad access per cycle. Write and read never coincide because FILL and READ are exclusive states.

## Timing
- Reset values: `cfg_ready`=1, all other outputs 0, FSM in IDLE, pointers and counters 0.
- Reset mid-job: control returns to IDLE immediately. Scratchpad contents are not cleared; a later keep job replays them.
- Handshake rule: a transfer occurs on a rising edge where valid and ready are both high. `out_valid`, `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- Cfg handshake at cycle 0: FSM enters FILL at cycle 1, and `in_ready`=1 from cycle 1.
- Last fill handshake at cycle k: READ at k+1, first `out_valid` at k+2 (1-cycle read latency).
- With `out_ready` held high: one word per cycle across pass boundaries, with no bubble at the wrap.
- `done` rises exactly 1 cycle after the final output handshake. `cfg_ready` returns high in that same cycle.
- `in_valid` outside FILL is ignored, since `in_ready`=0.

## Configuration
- `PE_SPAD_CTRL_PERF_EN` defined: adds output `stall_cnt` (16 bits, reset 0).
  - Increments each cycle with `out_valid && !out_ready`.
  - Saturates at 0xFFFF.
  - Clears on each cfg handshake.
- `PE_SPAD_CTRL_PERF_EN` undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `pe_pkg` holds:
  - the FSM state enum (`SPAD_IDLE`, `SPAD_FILL`, `SPAD_READ`, `SPAD_DRAIN`);
  - the job descriptor struct (len, reuse, keep).
- One sub-module, `pe_spad_outreg`: the WIDTH+1-bit output register with valid and load/hold logic. The address and pass sequencing stay in the top module.
- The scratchpad itself is instantiated by the PE top, not by this block.

## Test plan
- Reset with `out_ready`=1, len=4, reuse=0, fill 0x11..0x14 → 4 writes to addresses 0..3; outputs 0x11,0x12,0x13,0x14 on consecutive cycles; `out_last` on 0x14; `done` 1 cycle later.
- len=3, reuse=2, data A,B,C → 9 outputs A,B,C,A,B,C,A,B,C; `out_last` on each C; no bubble at the wraps.
- Toggle `out_ready` 1,0,0,1 during READ → `out_data` holds across the stall; no word lost or duplicated. With the macro defined, `stall_cnt`=2.
- Second job with keep=1, len=3, after the job above → no `in_ready`, no `spad_wen`; outputs A,B,C.
- len=0 → `done` pulses 1 cycle after the cfg handshake; `in_ready` and `out_valid` stay 0. len=100 with SIZE=64 → exactly 64 fill handshakes.
- Assert `rst_n`=0 after 2 of 4 fill words → all outputs reach reset values at once; a new job with len=2 completes normally.

Source files
------------

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared PE definitions: the scratchpad controller FSM state encoding and the
// job descriptor latched at the start of every scratchpad job.
//
// Contents:
//   spad_state_t : SPAD_IDLE / SPAD_FILL / SPAD_READ / SPAD_DRAIN
//   spad_job_t   : len (words per pass, already clamped), reuse (extra
//                  passes), keep (replay without refilling)
// -----------------------------------------------------------------------------
package pe_pkg;

  // Wide enough for any scratchpad address width up to 16 bits plus one;
  // users zero-extend their ADDR+1 bit length into it.
  localparam int SPAD_LEN_W = 17;

  typedef enum logic [1:0] {
    SPAD_IDLE,
    SPAD_FILL,
    SPAD_READ,
    SPAD_DRAIN
  } spad_state_t;

  typedef struct packed {
    logic [SPAD_LEN_W-1:0] len;
    logic [7:0]            reuse;
    logic                  keep;
  } spad_job_t;

endpackage

// File: rtl/pe_spad_outreg.sv
// -----------------------------------------------------------------------------
// pe_spad_outreg
// Registered, back-pressurable output stage toward the MAC. Holds one
// WIDTH-bit word plus its last flag. A load always wins; otherwise the word
// is dropped once the consumer takes it. The caller only asserts load when
// the register is empty or being consumed, so nothing is ever overwritten.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load                  : capture load_data/load_last this cycle
//   load_data, load_last  : word and end-of-pass flag to capture
//   out_ready             : consumer ready
//   out_valid, out_data,
//   out_last              : registered output stream
// -----------------------------------------------------------------------------
module pe_spad_outreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  logic [WIDTH:0] word_q;
  logic           valid_q;

  // Load has priority; an unreplaced word clears its valid when consumed and
  // otherwise holds stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      word_q  <= {load_last, load_data};
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = word_q[WIDTH-1:0];
  assign out_last  = word_q[WIDTH];

endmodule

// File: rtl/pe_spad_ctrl.sv
// -----------------------------------------------------------------------------
// pe_spad_ctrl
// Sequences one PE scratchpad: a job descriptor selects len words, which are
// streamed in from the global-buffer side (FILL) and then replayed reuse+1
// times to the MAC through a registered output (READ, then DRAIN while the
// last word waits to be taken). keep=1 skips FILL and replays what is already
// in the scratchpad.
//
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready, cfg_len,
//   cfg_reuse, cfg_keep               : job descriptor handshake
//   in_valid/in_ready, in_data        : fill stream
//   out_valid/out_ready, out_data,
//   out_last                          : read stream to the MAC
//   done                              : one-cycle job-complete pulse
//   spad_wen, spad_addr, spad_wrdata,
//   spad_rdata                        : scratchpad pins (combinational read)
//   stall_cnt                         : only with PE_SPAD_CTRL_PERF_EN defined;
//                                       saturating count of output stalls
//                                       since the last cfg handshake
// -----------------------------------------------------------------------------
module pe_spad_ctrl
  import pe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 6,
  parameter int SIZE  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ADDR:0]    cfg_len,
  input  logic [7:0]       cfg_reuse,
  input  logic             cfg_keep,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             spad_wen,
  output logic [ADDR-1:0]  spad_addr,
  output logic [WIDTH-1:0] spad_wrdata,
  input  logic [WIDTH-1:0] spad_rdata
`ifdef PE_SPAD_CTRL_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int            LW     = ADDR + 1;
  localparam logic [LW-1:0] SIZE_L = LW'(SIZE);

  spad_state_t     state_q, state_d;
  spad_job_t       job_q;
  logic [ADDR-1:0] wr_ptr_q, rd_ptr_q, last_idx;
  logic [8:0]      pass_q;
  logic            done_q;
  logic [LW-1:0]   cfg_len_clamped;
  logic            cfg_fire, fill_fire, out_fire, issue, rd_wrap, final_pass;

  assign cfg_len_clamped = (cfg_len > SIZE_L) ? SIZE_L : cfg_len;
  // len never exceeds SIZE <= 2^ADDR, so len-1 always fits in ADDR bits.
  assign last_idx   = ADDR'(job_q.len - SPAD_LEN_W'(1));

  assign cfg_ready  = (state_q == SPAD_IDLE);
  assign cfg_fire   = cfg_valid && cfg_ready;
  // A keep job never reaches FILL; the extra term keeps it from ever writing.
  assign in_ready   = (state_q == SPAD_FILL) && !job_q.keep;
  assign fill_fire  = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  // Issue whenever the output register is free or drains this very cycle,
  // which gives back-to-back words across pass boundaries.
  assign issue      = (state_q == SPAD_READ) && (!out_valid || out_ready);
  assign rd_wrap    = (rd_ptr_q == last_idx);
  assign final_pass = (pass_q == {1'b0, job_q.reuse});
  assign done       = done_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SPAD_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and scratchpad pin drive; only FILL and READ touch the
  // scratchpad, so write and read can never collide.
  always_comb begin
    state_d     = state_q;
    spad_wen    = 1'b0;
    spad_addr   = '0;
    spad_wrdata = '0;
    case (state_q)
      SPAD_IDLE: begin
        if (cfg_fire && (cfg_len_clamped != '0))
          state_d = cfg_keep ? SPAD_READ : SPAD_FILL;
      end
      SPAD_FILL: begin
        spad_addr = wr_ptr_q;
        if (fill_fire) begin
          spad_wen    = 1'b1;
          spad_wrdata = in_data;
          if (wr_ptr_q == last_idx) state_d = SPAD_READ;
        end
      end
      SPAD_READ: begin
        spad_addr = rd_ptr_q;
        if (issue && rd_wrap && final_pass) state_d = SPAD_DRAIN;
      end
      SPAD_DRAIN: begin
        if (out_fire) state_d = SPAD_IDLE;
      end
      default: state_d = SPAD_IDLE;
    endcase
  end

  // Job latch, write/read pointers and pass counter. The done pulse covers
  // both the empty job and the final word being taken in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (cfg_fire && (cfg_len_clamped == '0)) ||
                ((state_q == SPAD_DRAIN) && out_fire);
      if (cfg_fire) begin
        job_q.len   <= SPAD_LEN_W'(cfg_len_clamped);
        job_q.reuse <= cfg_reuse;
        job_q.keep  <= cfg_keep;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        pass_q      <= '0;
      end else begin
        if (fill_fire) wr_ptr_q <= wr_ptr_q + ADDR'(1);
        if (issue) begin
          if (rd_wrap) begin
            rd_ptr_q <= '0;
            pass_q   <= pass_q + 9'd1;
          end else begin
            rd_ptr_q <= rd_ptr_q + ADDR'(1);
          end
        end
      end
    end
  end

  pe_spad_outreg #(
    .WIDTH(WIDTH)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (issue),
    .load_data (spad_rdata),
    .load_last (rd_wrap),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

`ifdef PE_SPAD_CTRL_PERF_EN
  // Saturating count of cycles the MAC leaves a valid word waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (cfg_fire)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
